// File: rtl/alu_arbiter_ctrl.sv
// rtl/alu_arbiter_ctrl.sv - round-robin two-requester front-end for a shared combinational ALU (optional ALU_ARB_STATS_EN)
module alu_arbiter_ctrl #(
    parameter int NB_OPERANDO = 8,
    parameter int NB_OPCODE   = 6,
    parameter int NB_OUT      = 8,
    parameter int NB_STAT     = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [NB_OPERANDO-1:0] req0_dato_a,
    input  logic [NB_OPERANDO-1:0] req0_dato_b,
    input  logic [NB_OPCODE-1:0]   req0_opcode,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [NB_OPERANDO-1:0] req1_dato_a,
    input  logic [NB_OPERANDO-1:0] req1_dato_b,
    input  logic [NB_OPCODE-1:0]   req1_opcode,
    output logic [NB_OPERANDO-1:0] alu_dato_a,
    output logic [NB_OPERANDO-1:0] alu_dato_b,
    output logic [NB_OPCODE-1:0]   alu_opcode,
    input  logic [NB_OUT-1:0]      alu_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [NB_OUT-1:0]      resp_data,
    output logic                   resp_id,
    output logic                   resp_err,
`ifdef ALU_ARB_STATS_EN
    output logic [NB_STAT-1:0]     stat_cnt0,
    output logic [NB_STAT-1:0]     stat_cnt1,
    output logic [NB_STAT-1:0]     stat_err,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   id_q, id_d;
    logic [NB_OPERANDO-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [NB_OPCODE-1:0]   alu_op_q, alu_op_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [NB_OUT-1:0]      resp_data_q, resp_data_d;
    logic                   resp_id_q, resp_id_d;
    logic                   resp_err_q, resp_err_d;
    logic                   grant0, grant1, op_legal, resp_hs;

    always_comb begin
        case (alu_op_q)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    end

    // On contention the requester that did not win last time is granted.
    assign grant0  = req0_valid && (!req1_valid || last_grant_q);
    assign grant1  = req1_valid && (!req0_valid || !last_grant_q);
    assign resp_hs = (state_q == RESP) && resp_valid_q && resp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    alu_a_d      = req0_dato_a;
                    alu_b_d      = req0_dato_b;
                    alu_op_d     = req0_opcode;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (grant1) begin
                    alu_a_d      = req1_dato_a;
                    alu_b_d      = req1_dato_b;
                    alu_op_d     = req1_opcode;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = op_legal ? alu_out : '0;
                resp_err_d   = !op_legal;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NB_STAT-1:0] stat_cnt0_q, stat_cnt0_d, stat_cnt1_q, stat_cnt1_d, stat_err_q, stat_err_d;

    always_comb begin
        stat_cnt0_d = stat_cnt0_q;
        stat_cnt1_d = stat_cnt1_q;
        stat_err_d  = stat_err_q;
        if (resp_hs) begin
            if (!resp_id_q && stat_cnt0_q != '1) stat_cnt0_d = stat_cnt0_q + NB_STAT'(1);
            if (resp_id_q && stat_cnt1_q != '1)  stat_cnt1_d = stat_cnt1_q + NB_STAT'(1);
            if (resp_err_q && stat_err_q != '1)  stat_err_d  = stat_err_q + NB_STAT'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_cnt0_q <= '0;
            stat_cnt1_q <= '0;
            stat_err_q  <= '0;
        end else begin
            stat_cnt0_q <= stat_cnt0_d;
            stat_cnt1_q <= stat_cnt1_d;
            stat_err_q  <= stat_err_d;
        end
    end

    assign stat_cnt0 = stat_cnt0_q;
    assign stat_cnt1 = stat_cnt1_q;
    assign stat_err  = stat_err_q;
`endif

    assign alu_dato_a = alu_a_q;
    assign alu_dato_b = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb/tb_alu_arbiter_ctrl.sv - directed-vector bench for alu_arbiter_ctrl
module tb_alu_arbiter_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_dato_a, req0_dato_b, req1_dato_a, req1_dato_b;
    logic [5:0] req0_opcode, req1_opcode;
    logic [7:0] alu_dato_a, alu_dato_b, alu_out;
    logic [5:0] alu_opcode;
    logic       resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [7:0] resp_data;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1, stat_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_arbiter_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dato_a(req0_dato_a), .req0_dato_b(req0_dato_b), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dato_a(req1_dato_a), .req1_dato_b(req1_dato_b), .req1_opcode(req1_opcode),
        .alu_dato_a(alu_dato_a), .alu_dato_b(alu_dato_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err),
`ifdef ALU_ARB_STATS_EN
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_err(stat_err),
`endif
        .busy(busy)
    );

    // External ALU; illegal opcodes yield a nonzero value so result masking is visible.
    always_comb begin
        case (alu_opcode)
            6'b100000: alu_out = alu_dato_a + alu_dato_b;
            6'b100010: alu_out = alu_dato_a - alu_dato_b;
            6'b100100: alu_out = alu_dato_a & alu_dato_b;
            6'b100101: alu_out = alu_dato_a | alu_dato_b;
            6'b100110: alu_out = alu_dato_a ^ alu_dato_b;
            6'b100111: alu_out = ~(alu_dato_a | alu_dato_b);
            6'b000011: alu_out = $unsigned($signed(alu_dato_a) >>> alu_dato_b);
            6'b000010: alu_out = alu_dato_a >> alu_dato_b;
            default:   alu_out = 8'hFF;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op);
        if (id) begin
            req1_valid = v; req1_dato_a = a; req1_dato_b = b; req1_opcode = op;
        end else begin
            req0_valid = v; req0_dato_a = a; req0_dato_b = b; req0_opcode = op;
        end
    endtask

    // Single command from one requester with resp_ready=1; inputs driven and sampled at negedge.
    task automatic single(input string tag, input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op, input logic [7:0] exp_data, input bit exp_err);
        set_req(id, 1'b1, a, b, op);
        #1;
        check_eq({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
        @(negedge clock);
        set_req(id, 1'b0, 8'h00, 8'h00, 6'h00);
        check_eq({tag, "_exec"}, {busy, resp_valid, req0_ready, req1_ready}, 4'b1000);
        @(negedge clock);
        check_eq({tag, "_resp"}, {busy, resp_valid, resp_id, resp_err, resp_data},
                 {1'b1, 1'b1, id, exp_err, exp_data});
        @(negedge clock);
        check_eq({tag, "_done"}, {busy, resp_valid}, 2'b00);
    endtask

    task automatic collect(input string tag, input bit exp_id, input logic [7:0] exp_data);
        int t;
        t = 0;
        while (!resp_valid && t < 10) begin
            @(negedge clock);
            t++;
        end
        check_eq({tag, "_timeout"}, resp_valid, 1'b1);
        check_eq({tag, "_idata"}, {resp_id, resp_data}, {exp_id, exp_data});
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; resp_ready = 1'b1;
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check_eq("reset_outs", {busy, resp_valid, resp_id, resp_err, resp_data, alu_dato_a,
                                alu_dato_b, alu_opcode}, 32'h0);

        single("add", 1'b0, 8'h05, 8'h03, 6'b100000, 8'h08, 1'b0);
        check_eq("alu_hold", {alu_dato_a, alu_dato_b, alu_opcode}, {8'h05, 8'h03, 6'b100000});
        single("illegal", 1'b1, 8'hAA, 8'h55, 6'b111111, 8'h00, 1'b1);
        single("sra", 1'b0, 8'h80, 8'h02, 6'b000011, 8'hE0, 1'b0);
        single("srl", 1'b1, 8'h80, 8'h02, 6'b000010, 8'h20, 1'b0);
        single("nor", 1'b0, 8'h0F, 8'hF0, 6'b100111, 8'h00, 1'b0);
        single("xor", 1'b1, 8'h0F, 8'hFF, 6'b100110, 8'hF0, 1'b0);

        // Stall with backpressure; req1 waiting must not be accepted.
        resp_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'h21, 8'h12, 6'b100101);
        @(negedge clock);
        set_req(1'b0, 1'b1, 8'h00, 8'h00, 6'b100000);
        set_req(1'b1, 1'b1, 8'h01, 8'h01, 6'b100000);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_hold", {resp_valid, resp_id, resp_data, req0_ready, req1_ready},
                     {1'b1, 1'b0, 8'h33, 2'b00});
            @(negedge clock);
        end
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        resp_ready = 1'b1;
        @(negedge clock);
        check_eq("stall_release", {busy, resp_valid, req1_ready}, 3'b001);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);

        // req0 accepted last -> last_grant=0; reset in EXEC must restore req0 priority.
        set_req(1'b0, 1'b1, 8'h01, 8'h02, 6'b100000);
        @(negedge clock);
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("rst_exec", {busy, resp_valid, alu_dato_a, alu_opcode}, 16'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_no_resp", resp_valid, 1'b0);

`ifdef ALU_ARB_STATS_EN
        single("st_a", 1'b0, 8'h01, 8'h01, 6'b100000, 8'h02, 1'b0);
        single("st_b", 1'b0, 8'h01, 8'h01, 6'b000000, 8'h00, 1'b1);
        single("st_c", 1'b0, 8'h03, 8'h01, 6'b100010, 8'h02, 1'b0);
        check_eq("stats", {stat_cnt0, stat_err}, {16'd3, 16'd1});
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
`endif

        // Contention: both held valid, responses must alternate starting with requester 0.
        set_req(1'b0, 1'b1, 8'h10, 8'h01, 6'b100010);
        set_req(1'b1, 1'b1, 8'hF0, 8'h3C, 6'b100100);
        collect("rr0", 1'b0, 8'h0F);
        collect("rr1", 1'b1, 8'h30);
        collect("rr2", 1'b0, 8'h0F);
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        set_req(1'b1, 1'b1, 8'hF0, 8'h3C, 6'b100100);
        collect("rr3", 1'b1, 8'h30);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
        @(negedge clock);
        check_eq("final_idle", {busy, resp_valid}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
